// File: rtl/prog_loader.sv
// Program loader: assembles a framed big-endian byte stream into 32-bit RAM words,
// holds the CPU in reset while loading, then hands the RAM port over to the CPU.
module prog_loader #(
    parameter int SIZE  = 14,
    parameter int DEPTH = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_start,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic            byte_ready,
    input  logic            cpu_wrEn,
    input  logic [SIZE-1:0] cpu_addr,
    input  logic [31:0]     cpu_data,
    output logic            ram_wrEn,
    output logic [SIZE-1:0] ram_addr,
    output logic [31:0]     ram_data,
    output logic            cpu_rst,
    output logic            done,
    output logic            error
);
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, RUN, ERR} state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t          state_q, state_d;
    logic [7:0]      nhi_q, nhi_d;
    logic [15:0]     count_q, count_d;
    logic [15:0]     index_q, index_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [31:0]     word_q, word_d;
    logic            byte_ready_q, byte_ready_d;
    logic            wr_en_q, wr_en_d;
    logic [SIZE-1:0] addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            xfer;

    assign xfer = byte_valid & byte_ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            nhi_q        <= '0;
            count_q      <= '0;
            index_q      <= '0;
            bcnt_q       <= '0;
            word_q       <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            nhi_q        <= nhi_d;
            count_q      <= count_d;
            index_q      <= index_d;
            bcnt_q       <= bcnt_d;
            word_q       <= word_d;
            byte_ready_q <= byte_ready_d;
            wr_en_q      <= wr_en_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            cpu_rst_q    <= cpu_rst_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // load_start overrides everything, so a byte arriving with it is dropped.
    always_comb begin
        state_d = state_q;
        nhi_d   = nhi_q;
        count_d = count_q;
        index_d = index_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        if (load_start) begin
            state_d = HDR0;
            index_d = '0;
            bcnt_d  = '0;
        end else begin
            case (state_q)
                HDR0: if (xfer) begin
                    nhi_d   = byte_data;
                    state_d = HDR1;
                end
                HDR1: if (xfer) begin
                    count_d = {nhi_q, byte_data};
                    index_d = '0;
                    bcnt_d  = '0;
                    if (count_d == 16'd0)
                        state_d = RUN;
                    else if (count_d > DEPTH_W)
                        state_d = ERR;
                    else
                        state_d = DATA;
                end
                DATA: if (xfer) begin
                    word_d = {word_q[23:0], byte_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3)
                        state_d = WRITE;
                end
                WRITE: begin
                    index_d = index_q + 16'd1;
                    state_d = (index_d == count_q) ? RUN : DATA;
                end
                default: ;
            endcase
        end
    end

    // Outputs are registered decodes of the upcoming state.
    always_comb begin
        byte_ready_d = (state_d == HDR0) || (state_d == HDR1) || (state_d == DATA);
        wr_en_d      = (state_d == WRITE);
        addr_d       = addr_q;
        data_d       = data_q;
        if (state_d == WRITE) begin
            addr_d = index_q[SIZE-1:0];
            data_d = word_d;
        end
        cpu_rst_d = (state_d != RUN);
        done_d    = (state_d == RUN);
        error_d   = (state_d == ERR);
    end

    assign byte_ready = byte_ready_q;
    assign cpu_rst    = cpu_rst_q;
    assign done       = done_q;
    assign error      = error_q;
    assign ram_wrEn   = (state_q == RUN) ? cpu_wrEn : wr_en_q;
    assign ram_addr   = (state_q == RUN) ? cpu_addr : addr_q;
    assign ram_data   = (state_q == RUN) ? cpu_data : data_q;
endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader and RAM-port mux that sits directly upstream of the block RAM, between the byte-stream host link and `blram`. It accepts a framed byte stream, assembles 32-bit words and writes them to RAM starting at address 0. It holds `VerySimpleCPU` in reset during loading, then hands the RAM port to the CPU. This replaces the simulation-only `initial` memory image with a loadable program path.

## Interface

Parameters:
- `SIZE`, 14, RAM address width.
- `DEPTH`, 1024, maximum loadable word count (RAM depth).

Ports:
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  reset, asynchronous and active-low (0 = reset).
- `load_start`  input  1  single-cycle pulse; starts or restarts a load.
- `byte_valid`  input  1  host byte strobe.
- `byte_data`  input  8  host byte.
- `byte_ready`  output  1  loader accepts a byte; a transfer occurs when `byte_valid & byte_ready`.
- `cpu_wrEn`  input  1  CPU write enable.
- `cpu_addr`  input  SIZE  CPU address.
- `cpu_data`  input  32  CPU write data.
- `ram_wrEn`  output  1  to `blram` `i_we`.
- `ram_addr`  output  SIZE  to `blram` `i_addr`.
- `ram_data`  output  32  to `blram` `i_ram_data_in`.
- `cpu_rst`  output  1  active-high reset to `VerySimpleCPU`.
- `done`  output  1  load complete; CPU running.
- `error`  output  1  frame rejected.

## Operation

Frame format: a 2-byte word count N, big-endian (N[15:8] first). This is followed by N words of 4 bytes each, big-endian (bits 31:24 first). Word k is written to address k for k = 0..N-1.

States:
- IDLE: entered on reset. `byte_ready`=0, `cpu_rst`=1. Leaves only on `load_start`.
- HDR0: `byte_ready`=1. On transfer, latch N[15:8] and go to HDR1.
- HDR1: `byte_ready`=1. On transfer, latch N[7:0]. Next state:
  - N==0 → RUN.
  - N>DEPTH → ERR.
  - otherwise → DATA, with word index=0 and byte count=0.
- DATA: `byte_ready`=1. Each transfer shifts the byte into the word register (`word = {word[23:0], byte}`). On the 4th byte, go to WRITE.
- WRITE: one cycle; `byte_ready`=0.
  - Drives `ram_wrEn`=1, `ram_addr`=index, `ram_data`=word.
  - Then index+1. If index+1==N → RUN, else → DATA.
- RUN: `cpu_rst`=0, `done`=1, `byte_ready`=0. The RAM port passes `cpu_*` through combinationally.
- ERR: `error`=1, `cpu_rst`=1, `byte_ready`=0. Held until `load_start`.

Rules that apply in all states:
- `load_start` in any state goes to HDR0 on the next cycle. It clears index, byte count, `error` and `done`, and asserts `cpu_rst`.
- A byte transferred in the same cycle as `load_start` is consumed and discarded.
- Mux: outside RUN, the RAM port is driven by the loader's registered outputs. `ram_wrEn`=0 except in WRITE, and CPU writes are ignored.
- Index and N are 16-bit internally. `ram_addr` is `index[SIZE-1:0]`. The count compare uses the full 16 bits, with no wrap.

## Timing

- Reset values (asynchronous, while `rst`=0): state IDLE, `byte_ready`=0, `ram_wrEn`=0, `ram_addr`=0, `ram_data`=0, `cpu_rst`=1, `done`=0, `error`=0.
- Reset asserted mid-load aborts immediately to IDLE. RAM contents already written are left as they are.
- `byte_ready` is a registered state decode and does not depend combinationally on `byte_valid`. Gaps in `byte_valid` stall the loader indefinitely with no timeout.
- Latency: the 4th byte is accepted in cycle t, and `ram_wrEn` is high in cycle t+1. The loader accepts bytes again in t+2.
  - Peak throughput is 4 bytes per 5 cycles.
- After the last WRITE (cycle t), state is RUN and `cpu_rst`=0 in cycle t+1. The CPU's first fetch therefore sees all words written.
- For N==0, HDR1's transfer in cycle t gives RUN in t+1.
- `done` and `error` are never high simultaneously.

## Test plan

- Load N=3 (bytes 00 03, then 20 11 40 45, 10 11 40 01, 00 00 00 00) with `byte_valid` held high.
  - Required: writes at addresses 0, 1, 2 with 0x20114045, 0x10114001, 0x00000000, one `ram_wrEn` pulse each.
  - Then `done`=1 and `cpu_rst`=0, and a CPU write to address 101 passes to the RAM in the same cycle.
- Same frame with `byte_valid` toggling randomly.
  - Required: identical RAM writes and final state; no byte is dropped or duplicated.
- N=0 (bytes 00 00).
  - Required: RUN one cycle after the second byte, with no `ram_wrEn` pulse.
- N=1025 (bytes 04 01).
  - Required: `error`=1, `cpu_rst`=1, `byte_ready`=0 and no writes.
  - A subsequent `load_start` followed by a valid N=1 frame completes normally and clears `error`.
- `load_start` pulsed after 2 data bytes.
  - Required: HDR0 on the next cycle; the partial word is never written; a new N=1 frame writes address 0.
- `rst` driven low in DATA for one cycle, asynchronously relative to `clk`.
  - Required: outputs go to their reset values immediately and IDLE holds until `load_start`.
